// File: rtl/obi_ram_bridge.sv
// obi_ram_bridge: adapts a core-side OBI data interface onto a single-port RAM with a
// one-cycle registered read. Every grant produces exactly one response one cycle later.
// Addresses above the RAM window are granted but answered with an error, no RAM access.
//
// Optional feature: define RANDOM_STALL_EN to insert 0..STALL_MAX pseudo-random grant-stall
// cycles per request (16-bit Fibonacci LFSR). Without it the grant is combinational.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   data_req_i/gnt_o     OBI request / grant
//   data_addr_i/we_i/be_i/wdata_i   OBI request payload
//   data_rvalid_o/rdata_o/err_o     OBI response (fixed latency 1)
//   ram_en_o/addr_o/wdata_o/we_o/be_o   RAM command (word-aligned byte address)
//   ram_rdata_i          RAM read data, valid the cycle after a read command
module obi_ram_bridge #(
    parameter int unsigned ADDR_WIDTH = 22,
    parameter int unsigned STALL_MAX  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
);

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    localparam logic [1:0] StallMax = (STALL_MAX > 3) ? 2'd3 : 2'(STALL_MAX);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] stall_raw, stall_n;
    logic       gnt, gnt_ok, oor;
    logic       rvalid_q, rvalid_d, err_q, err_d, is_read_q, is_read_d;
    logic       unused_addr_lsb;

    assign unused_addr_lsb = ^data_addr_i[1:0];

`ifdef RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;

    // Right-shifting form of the x^16+x^14+x^13+x^11+1 polynomial.
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign lfsr_d    = {lfsr_fb, lfsr_q[15:1]};
    assign stall_raw = lfsr_q[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall_raw = 2'd0;
`endif

    assign stall_n = (stall_raw > StallMax) ? StallMax : stall_raw;

    // Upper address bits outside the RAM window flag an error response.
    if (ADDR_WIDTH < 32) begin : g_oor
        assign oor = |data_addr_i[31:ADDR_WIDTH];
    end else begin : g_no_oor
        assign oor = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_req_i) begin
                    if (stall_n == 2'd0) begin
                        gnt = 1'b1;
                    end else begin
                        state_d = StStall;
                        cnt_d   = stall_n;
                    end
                end
            end
            StStall: begin
                if (!data_req_i) begin
                    // Request withdrawn mid-stall: abandon it silently.
                    state_d = StIdle;
                    cnt_d   = 2'd0;
                end else if (cnt_q == 2'd1) begin
                    gnt     = 1'b1;
                    state_d = StIdle;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // Gate with reset so nothing is granted while the bridge is held in reset.
    assign gnt_ok      = gnt & rst_ni;
    assign data_gnt_o  = gnt_ok;
    assign ram_en_o    = gnt_ok & ~oor;
    assign ram_we_o    = ram_en_o & data_we_i;
    assign ram_addr_o  = {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign ram_be_o    = data_be_i;
    assign ram_wdata_o = data_wdata_i;

    assign rvalid_d  = gnt_ok;
    assign err_d     = gnt_ok & oor;
    assign is_read_d = gnt_ok & ~data_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= 2'd0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            is_read_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            is_read_q <= is_read_d;
        end
    end

    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = rvalid_q & err_q;
    assign data_rdata_o  = (rvalid_q & is_read_q & ~err_q) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_obi_ram_bridge.sv
module tb_obi_ram_bridge;

    localparam int unsigned AW = 22;
    localparam int unsigned SM = 3;
`ifdef RANDOM_STALL_EN
    localparam int MAX_LAT = SM + 1;
`else
    localparam int MAX_LAT = 1;
`endif

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          data_req_i = 1'b0;
    logic          data_gnt_o;
    logic [31:0]   data_addr_i = '0;
    logic          data_we_i = 1'b0;
    logic [3:0]    data_be_i = '0;
    logic [31:0]   data_wdata_i = '0;
    logic          data_rvalid_o;
    logic [31:0]   data_rdata_o;
    logic          data_err_o;
    logic          ram_en_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic          ram_we_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   ram_rdata_i;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    bit [31:0]   ref_mem [256];
    bit [31:0]   ram_mem [256];
    bit          ram_init = 1'b0;
    logic [31:0] ram_w;

    obi_ram_bridge #(.ADDR_WIDTH(AW), .STALL_MAX(SM)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_req_i   (data_req_i),
        .data_gnt_o   (data_gnt_o),
        .data_addr_i  (data_addr_i),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_wdata_i (data_wdata_i),
        .data_rvalid_o(data_rvalid_o),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o),
        .ram_en_o     (ram_en_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_we_o     (ram_we_o),
        .ram_be_o     (ram_be_o),
        .ram_rdata_i  (ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // RAM with one-cycle registered read, driven purely by the DUT's RAM port.
    always @(posedge clk_i) begin
        if (!ram_init) begin
            ram_mem[64] <= 32'hDEADBEEF;
            ram_init    <= 1'b1;
        end else if (ram_en_o) begin
            if (ram_we_o) begin
                ram_w = ram_mem[ram_addr_o[9:2]];
                for (int b = 0; b < 4; b++) begin
                    if (ram_be_o[b]) ram_w[8*b+:8] = ram_wdata_o[8*b+:8];
                end
                ram_mem[ram_addr_o[9:2]] <= ram_w;
            end else begin
                ram_rdata_i <= ram_mem[ram_addr_o[9:2]];
            end
        end
    end

    // Response monitor: every rvalid must match the oldest expected response.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            checks++;
            if (ram_en_o === 1'b1 && data_gnt_o !== 1'b1) begin
                failures++;
                $display("FAIL ram_en_without_gnt: ram_en=%b gnt=%b required gnt=1", ram_en_o,
                         data_gnt_o);
            end
            if (data_rvalid_o === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rvalid: rvalid=1 at cycle %0d required none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (data_err_o !== mon_e.err || data_rdata_o !== mon_e.rdata ||
                        cyc !== mon_e.cyc) begin
                        failures++;
                        $display("FAIL rsp: err=%b rdata=%h cyc=%0d required err=%b rdata=%h cyc=%0d",
                                 data_err_o, data_rdata_o, cyc, mon_e.err, mon_e.rdata, mon_e.cyc);
                    end
                end
            end else begin
                checks++;
                if (data_err_o !== 1'b0 || data_rdata_o !== 32'h0 || data_rvalid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_rsp: rvalid=%b err=%b rdata=%h required 0/0/0",
                             data_rvalid_o, data_err_o, data_rdata_o);
                end
            end
        end
    end

    // Issue one request, hold it until granted, record the expected response.
    // Entered and left at #1 after a rising edge; the request is left asserted.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output int lat);
        exp_t        x;
        logic        oor;
        logic [31:0] w;
        bit          done;
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wdata;
        oor  = |addr[31:AW];
        lat  = 0;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk_i);
            lat++;
            if (data_gnt_o === 1'b1) begin
                done = 1'b1;
                checks++;
                if (oor) begin
                    if (ram_en_o !== 1'b0 || ram_we_o !== 1'b0) begin
                        failures++;
                        $display("FAIL ram_cmd_oor: en=%b we=%b required 0/0", ram_en_o, ram_we_o);
                    end
                end else if (ram_en_o !== 1'b1 || ram_addr_o !== {addr[AW-1:2], 2'b00} ||
                             ram_we_o !== we || ram_be_o !== be || ram_wdata_o !== wdata) begin
                    failures++;
                    $display("FAIL ram_cmd: en=%b addr=%h we=%b be=%b wd=%h required 1/%h/%b/%b/%h",
                             ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
                             {addr[AW-1:2], 2'b00}, we, be, wdata);
                end
                x.cyc = cyc + 1;
                if (oor) begin
                    x.err   = 1'b1;
                    x.rdata = 32'h0;
                end else if (we) begin
                    x.err   = 1'b0;
                    x.rdata = 32'h0;
                    w = ref_mem[addr[9:2]];
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) w[8*b+:8] = wdata[8*b+:8];
                    end
                    ref_mem[addr[9:2]] = w;
                end else begin
                    x.err   = 1'b0;
                    x.rdata = ref_mem[addr[9:2]];
                end
                sb.push_back(x);
            end
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout: no gnt within 8 cycles for addr %h", addr);
            data_req_i = 1'b0;
        end
    endtask

    task automatic idle_cycles(input int n);
        data_req_i = 1'b0;
        data_we_i  = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_ni      = 1'b0;
        data_req_i  = 1'b1;
        data_addr_i = 32'h100;
        repeat (3) begin
            @(negedge clk_i);
            checks++;
            if (data_gnt_o !== 1'b0 || ram_en_o !== 1'b0 || data_rvalid_o !== 1'b0 ||
                data_err_o !== 1'b0 || data_rdata_o !== 32'h0) begin
                failures++;
                $display("FAIL reset_state: gnt=%b en=%b rvalid=%b err=%b rdata=%h required all 0",
                         data_gnt_o, ram_en_o, data_rvalid_o, data_err_o, data_rdata_o);
            end
        end
        data_req_i = 1'b0;
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_read;
        int lat;
        do_req(1'b0, 32'h100, 4'hF, 32'h0, lat);
        checks++;
        if (lat < 1 || lat > MAX_LAT) begin
            failures++;
            $display("FAIL read_latency: lat=%0d required 1..%0d", lat, MAX_LAT);
        end
        idle_cycles(2);
    endtask

    task automatic test_write;
        int lat;
        do_req(1'b1, 32'h203, 4'b0110, 32'h11223344, lat);
        checks++;
        if (lat < 1 || lat > MAX_LAT) begin
            failures++;
            $display("FAIL write_latency: lat=%0d required 1..%0d", lat, MAX_LAT);
        end
        idle_cycles(1);
        // Read back: only bytes 1 and 2 were written.
        do_req(1'b0, 32'h200, 4'hF, 32'h0, lat);
        idle_cycles(2);
    endtask

    task automatic test_out_of_range;
        int lat;
        do_req(1'b0, 32'h0040_0000, 4'hF, 32'h0, lat);
        idle_cycles(1);
        do_req(1'b1, 32'h8000_0010, 4'hF, 32'hCAFEF00D, lat);
        checks++;
        if (lat < 1 || lat > MAX_LAT) begin
            failures++;
            $display("FAIL oor_latency: lat=%0d required 1..%0d", lat, MAX_LAT);
        end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 32'(4 * i), 4'hF, 32'hA0A0_0000 + 32'(i), lat);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 32'(4 * i), 4'hF, 32'h0, lat);
            checks++;
            if (lat < 1 || lat > MAX_LAT) begin
                failures++;
                $display("FAIL b2b_latency[%0d]: lat=%0d required 1..%0d", i, lat, MAX_LAT);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_pending;
        int lat;
        do_req(1'b0, 32'h100, 4'hF, 32'h0, lat);
        // Response is now registered; kill it with reset.
        rst_ni     = 1'b0;
        data_req_i = 1'b0;
        sb.delete();
        repeat (2) begin
            @(negedge clk_i);
            checks++;
            if (data_rvalid_o !== 1'b0 || data_gnt_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_pending: rvalid=%b gnt=%b required 0/0", data_rvalid_o,
                         data_gnt_o);
            end
        end
        #2 rst_ni = 1'b1;
        idle_cycles(4);
    endtask

`ifdef RANDOM_STALL_EN
    // Find a request that stalls, then either reset or withdraw it mid-stall.
    task automatic stall_probe(input bit use_reset);
        exp_t x;
        bit   hit;
        hit = 1'b0;
        for (int a = 0; a < 50 && !hit; a++) begin
            data_req_i  = 1'b1;
            data_we_i   = 1'b0;
            data_addr_i = 32'h8;
            @(negedge clk_i);
            if (data_gnt_o === 1'b1) begin
                x.err   = 1'b0;
                x.rdata = ref_mem[2];
                x.cyc   = cyc + 1;
                sb.push_back(x);
                @(posedge clk_i);
                #1;
                idle_cycles(1);
            end else begin
                hit = 1'b1;
                #1;
                data_req_i = 1'b0;
                if (use_reset) rst_ni = 1'b0;
                repeat (4) begin
                    @(negedge clk_i);
                    checks++;
                    if (data_gnt_o !== 1'b0 || ram_en_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_abort: gnt=%b en=%b rvalid=%b required 0/0/0",
                                 data_gnt_o, ram_en_o, data_rvalid_o);
                    end
                end
                #2 rst_ni = 1'b1;
                @(posedge clk_i);
                #1;
                idle_cycles(3);
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL stall_probe: all 50 requests granted immediately, required a stall");
        end
    endtask

    task automatic test_random;
        int          lat;
        logic [31:0] addr;
        for (int i = 0; i < 200; i++) begin
            addr = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(AW, 31));
            do_req(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom, lat);
            checks++;
            if (lat < 1 || lat > MAX_LAT) begin
                failures++;
                $display("FAIL rand_latency[%0d]: lat=%0d required 1..%0d", i, lat, MAX_LAT);
            end
            idle_cycles(1);
        end
        idle_cycles(2);
    endtask
`endif

    initial begin
        ref_mem[64] = 32'hDEADBEEF;
        test_reset();
        test_read();
        test_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_pending();
`ifdef RANDOM_STALL_EN
        stall_probe(1'b1);
        stall_probe(1'b0);
        test_random();
`endif
        idle_cycles(3);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_rvalid: %0d responses outstanding required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
